// File: rtl/gold_nic_pkg.sv
// gold_nic_pkg: shared constants for the gold_ring network interface controller.
// Holds the register map, packet geometry and a status-word helper.
package gold_nic_pkg;

   localparam int PKT_W      = 64;
   localparam int PKT_VC_BIT = 63;

   localparam logic [1:0] NIC_ADDR_IB      = 2'd0;
   localparam logic [1:0] NIC_ADDR_IB_STAT = 2'd1;
   localparam logic [1:0] NIC_ADDR_OB      = 2'd2;
   localparam logic [1:0] NIC_ADDR_OB_STAT = 2'd3;

   // Zero-extend a one-bit flag into a full processor read word.
   function automatic logic [PKT_W-1:0] status_word(input logic flag);
      status_word = {{(PKT_W-1){1'b0}}, flag};
   endfunction

endpackage

// File: rtl/gold_nic_buf.sv
// gold_nic_buf: one-entry packet buffer with load, clear and a full flag.
// A load captures data and sets full; a clear drops full but keeps the data
// so that a later read of an empty slot returns the stale packet.
module gold_nic_buf
   import gold_nic_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic [PKT_W-1:0] d_i,
   output logic [PKT_W-1:0] q_o,
   output logic             full_o
);

   logic [PKT_W-1:0] data_q, data_d;
   logic             full_q, full_d;

   // Next-state selection: load has priority, callers never raise both.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load_i) begin
         data_d = d_i;
         full_d = 1'b1;
      end else if (clr_i) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Buffer storage and full flag, cleared by asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= {PKT_W{1'b0}};
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign q_o    = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/gold_nic.sv
// gold_nic: PE-side network interface for one gold_router port.
// Four-register processor map (ib, ib status, ob, ob status), one injection
// buffer and one ejection buffer. Optional build macro NIC_POLARITY_GATE_EN
// restricts injection to cycles whose ring polarity matches packet bit 63.
module gold_nic
   import gold_nic_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       addr,
   input  logic [PKT_W-1:0] d_in,
   output logic [PKT_W-1:0] d_out,
   input  logic             nicEn,
   input  logic             nicEnWr,
   output logic             net_so,
   input  logic             net_ro,
   output logic [PKT_W-1:0] net_do,
   input  logic             net_si,
   output logic             net_ri,
   input  logic [PKT_W-1:0] net_di,
   input  logic             net_polarity
);

   logic [PKT_W-1:0] ob_s, ib_s;
   logic             ob_full_s, ib_full_s;
   logic             ob_load_s, ob_clr_s, ib_load_s, ib_clr_s;
   logic             rd_s, wr_s, gate_s;
   logic [PKT_W-1:0] d_out_q, d_out_d;

   assign rd_s = nicEn & ~nicEnWr;
   assign wr_s = nicEn &  nicEnWr;

`ifdef NIC_POLARITY_GATE_EN
   assign gate_s = (ob_s[PKT_VC_BIT] == net_polarity);
`else
   logic unused_polarity_s;
   assign unused_polarity_s = net_polarity;
   assign gate_s            = 1'b1;
`endif

   // Handshakes depend only on buffer state and router inputs, never on addr/d_in.
   assign net_so    = ob_full_s & net_ro & gate_s;
   assign net_do    = ob_s;
   assign net_ri    = ~ib_full_s;

   // A write to a full ob is silently dropped; injection empties the slot.
   assign ob_load_s = wr_s & (addr == NIC_ADDR_OB) & ~ob_full_s;
   assign ob_clr_s  = net_so;

   // net_ri is low while full, so arrival and read-clear never coincide.
   assign ib_load_s = net_si & net_ri;
   assign ib_clr_s  = rd_s & (addr == NIC_ADDR_IB) & ib_full_s;

   gold_nic_buf u_ob (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (ob_load_s),
      .clr_i  (ob_clr_s),
      .d_i    (d_in),
      .q_o    (ob_s),
      .full_o (ob_full_s)
   );

   gold_nic_buf u_ib (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (ib_load_s),
      .clr_i  (ib_clr_s),
      .d_i    (net_di),
      .q_o    (ib_s),
      .full_o (ib_full_s)
   );

   // Read mux: select the addressed register, hold d_out when no read.
   always_comb begin
      d_out_d = d_out_q;
      if (rd_s) begin
         case (addr)
            NIC_ADDR_IB:      d_out_d = ib_s;
            NIC_ADDR_IB_STAT: d_out_d = status_word(ib_full_s);
            NIC_ADDR_OB:      d_out_d = ob_s;
            NIC_ADDR_OB_STAT: d_out_d = status_word(ob_full_s);
            default:          d_out_d = d_out_q;
         endcase
      end else begin
         d_out_d = d_out_q;
      end
   end

   // Registered processor read data, one cycle latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_out_q <= {PKT_W{1'b0}};
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: directed self-checking bench for gold_nic.
module tb_gold_nic;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [63:0] d_in = 64'd0;
   logic [63:0] d_out;
   logic        nicEn = 1'b0;
   logic        nicEnWr = 1'b0;
   logic        net_so;
   logic        net_ro = 1'b0;
   logic [63:0] net_do;
   logic        net_si = 1'b0;
   logic        net_ri;
   logic [63:0] net_di = 64'd0;
   logic        net_polarity = 1'b0;

   int checks = 0;
   int failures = 0;

   gold_nic dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicEnWr      (nicEnWr),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_polarity (net_polarity)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [63:0] v);
      nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = v;
      tick();
      nicEn = 1'b0; nicEnWr = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a);
      nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
      tick();
      nicEn = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; net_ro = 1'b0;
      #3;
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL reset_net_ri got=%b exp=1", net_ri); end
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
      checks++; if (net_do !== 64'd0) begin failures++; $display("FAIL reset_net_do got=%h exp=0", net_do); end
      tick(); tick();
      rst_ni = 1'b1;
      tick();
      do_read(2'd3);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL reset_ob_stat got=%h exp=0", d_out); end
   endtask

   task automatic test_inject();
      logic [63:0] pkt;
      int pulses;
      int first;
      int exp_first;
      pkt = 64'h8000_0000_0000_00AA;
`ifdef NIC_POLARITY_GATE_EN
      exp_first = 1;
`else
      exp_first = 0;
`endif
      pulses = 0; first = -1;
      net_ro = 1'b1; net_polarity = 1'b0;
      do_write(2'd2, pkt);
      for (int i = 0; i < 6; i++) begin
         net_polarity = (i % 2 == 1);
         #1;
         if (i == 0) begin
            checks++; if (net_do !== pkt) begin failures++; $display("FAIL inject_net_do got=%h exp=%h", net_do, pkt); end
         end
         if (net_so === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         tick();
      end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL inject_pulse_count got=%0d exp=1", pulses); end
      checks++; if (first !== exp_first) begin failures++; $display("FAIL inject_pulse_cycle got=%0d exp=%0d", first, exp_first); end
      net_ro = 1'b0;
      do_read(2'd3);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL inject_ob_stat got=%h exp=0", d_out); end
   endtask

   task automatic test_drop_full();
      net_ro = 1'b0; net_polarity = 1'b0;
      do_write(2'd2, 64'h11);
      do_write(2'd2, 64'h55);
      do_write(2'd0, 64'h99);
      do_read(2'd2);
      checks++; if (d_out !== 64'h11) begin failures++; $display("FAIL drop_ob_hold got=%h exp=11", d_out); end
      do_read(2'd3);
      checks++; if (d_out !== 64'd1) begin failures++; $display("FAIL drop_ob_stat got=%h exp=1", d_out); end
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL drop_net_so_blocked got=%b exp=0", net_so); end
      addr = 2'd0;
      tick();
      checks++; if (d_out !== 64'd1) begin failures++; $display("FAIL hold_d_out got=%h exp=1", d_out); end
      net_ro = 1'b1;
      #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL drop_net_so_release got=%b exp=1", net_so); end
      tick();
      net_ro = 1'b0;
      do_read(2'd3);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL drop_ob_drained got=%h exp=0", d_out); end
   endtask

   task automatic test_eject();
      net_si = 1'b1; net_di = 64'h1234;
      tick();
      net_si = 1'b0;
      checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL eject_net_ri_low got=%b exp=0", net_ri); end
      net_si = 1'b1; net_di = 64'h5678;
      tick();
      net_si = 1'b0;
      do_read(2'd1);
      checks++; if (d_out !== 64'd1) begin failures++; $display("FAIL eject_ib_stat got=%h exp=1", d_out); end
      do_read(2'd0);
      checks++; if (d_out !== 64'h1234) begin failures++; $display("FAIL eject_read got=%h exp=1234", d_out); end
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL eject_net_ri_free got=%b exp=1", net_ri); end
      net_si = 1'b1; net_di = 64'h5678;
      tick();
      net_si = 1'b0;
      checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL eject_second_capture got=%b exp=0", net_ri); end
      do_read(2'd0);
      checks++; if (d_out !== 64'h5678) begin failures++; $display("FAIL eject_second_read got=%h exp=5678", d_out); end
      do_read(2'd0);
      checks++; if (d_out !== 64'h5678) begin failures++; $display("FAIL eject_stale_read got=%h exp=5678", d_out); end
      do_read(2'd1);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL eject_empty_stat got=%h exp=0", d_out); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] p1;
      logic [63:0] p2;
      p1 = 64'h8000_0000_0000_0001;
      p2 = 64'h8000_0000_0000_0002;
      net_ro = 1'b1; net_polarity = 1'b1;
      do_write(2'd2, p1);
      checks++; if (net_so !== 1'b1 || net_do !== p1) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", net_so, net_do, p1); end
      tick();
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", net_so); end
      do_write(2'd2, p2);
      checks++; if (net_so !== 1'b1 || net_do !== p2) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", net_so, net_do, p2); end
      tick();
      net_ro = 1'b0;
      do_read(2'd3);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL b2b_ob_stat got=%h exp=0", d_out); end
   endtask

   task automatic test_reset_mid();
      net_ro = 1'b0;
      do_write(2'd2, 64'hDEAD);
      net_si = 1'b1; net_di = 64'hBEEF;
      tick();
      net_si = 1'b0;
      do_read(2'd1);
      checks++; if (d_out !== 64'd1) begin failures++; $display("FAIL mid_ib_full got=%h exp=1", d_out); end
      net_ro = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL mid_net_ri got=%b exp=1", net_ri); end
      checks++; if (net_so !== 1'b0 || net_do !== 64'd0) begin failures++; $display("FAIL mid_ob got=%b/%h exp=0/0", net_so, net_do); end
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL mid_d_out got=%h exp=0", d_out); end
      tick();
      rst_ni = 1'b1;
      net_ro = 1'b0;
      tick();
      do_read(2'd1);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL mid_ib_stat got=%h exp=0", d_out); end
      do_read(2'd3);
      checks++; if (d_out !== 64'd0) begin failures++; $display("FAIL mid_ob_stat got=%h exp=0", d_out); end
   endtask

   initial begin
      test_reset();
      test_inject();
      test_drop_full();
      test_eject();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
